// File: rtl/tnn_pkg.sv
// Shared types for the TNN neuron datapath: feature lane width, frame shape and framer states.
// Imported by the framer and by anything that consumes its frames.
package tnn_pkg;

    localparam int DEF_FEAT_W = 3;
    localparam int DEF_N_FEAT = 5;

    typedef logic [DEF_FEAT_W-1:0] feature_t;
    typedef feature_t [DEF_N_FEAT-1:0] frame_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        RESYNC = 2'd2
    } framer_state_e;

endpackage

// File: rtl/tnn_sat_counter.sv
// Event counter that either wraps or sticks at all-ones.
// Used for the emitted-frame count (wrapping) and the drop count (saturating).
module tnn_sat_counter
    import tnn_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;
    logic             w_step;

    assign w_at_max = &r_count;
    assign w_step   = i_inc & ~(SATURATE & w_at_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tnn_feature_framer.sv
// Assembles serial 3-bit features into N_FEAT-lane frames for a combinational neuron core,
// checking alignment against s_last and resynchronising after framing errors.
module tnn_feature_framer
    import tnn_pkg::*;
#(
    parameter int FEAT_W = DEF_FEAT_W,
    parameter int N_FEAT = DEF_N_FEAT,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [N_FEAT*FEAT_W-1:0] m_frame,
    output logic                     err_sync,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef logic [N_FEAT-1:0][FEAT_W-1:0] lanes_t;

    framer_state_e    r_state;
    framer_state_e    w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    lanes_t           r_buf;
    lanes_t           r_out;
    lanes_t           w_asm;
    logic             r_mvalid;
    logic             r_sready;
    logic             r_err;
    logic             r_resync_pend;
    logic             w_resync_pend_nxt;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_handoff;
    logic             w_load;
    logic             w_err;
    logic             w_drop_inc;

    assign w_accept    = s_valid & r_sready;
    assign w_slot_free = ~r_mvalid | m_ready;
    assign w_handoff   = r_mvalid & m_ready;

    // The completing beat goes straight into the output register via w_asm, giving 1-cycle latency.
    always_comb begin
        w_asm = r_buf;
        if ((r_state == FILL) && w_accept) begin
            w_asm[r_idx] = s_data;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_load            = 1'b0;
        w_err             = 1'b0;
        w_drop_inc        = 1'b0;
        w_resync_pend_nxt = r_resync_pend;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (r_idx != LAST_IDX) begin
                        if (s_last) begin
                            w_err      = 1'b1;
                            w_drop_inc = 1'b1;
                            w_idx_nxt  = '0;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_idx_nxt = '0;
                        w_err     = ~s_last;
                        if (w_slot_free) begin
                            w_load = 1'b1;
                            if (!s_last) begin
                                w_state_nxt = RESYNC;
                                w_drop_inc  = 1'b1;
                            end
                        end else begin
                            w_state_nxt       = HOLD;
                            w_resync_pend_nxt = ~s_last;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_slot_free) begin
                    w_load            = 1'b1;
                    w_resync_pend_nxt = 1'b0;
                    if (r_resync_pend) begin
                        w_state_nxt = RESYNC;
                        w_drop_inc  = 1'b1;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
            end
            RESYNC: begin
                if (w_accept && s_last) begin
                    w_state_nxt = FILL;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // s_ready is registered from the next state so m_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_buf         <= '0;
            r_out         <= '0;
            r_mvalid      <= 1'b0;
            r_sready      <= 1'b0;
            r_err         <= 1'b0;
            r_resync_pend <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_buf         <= w_asm;
            r_mvalid      <= w_load | (r_mvalid & ~m_ready);
            r_sready      <= (w_state_nxt != HOLD);
            r_err         <= w_err;
            r_resync_pend <= w_resync_pend_nxt;
            if (w_load) begin
                r_out <= w_asm;
            end
        end
    end

    tnn_sat_counter #(
        .WIDTH    (CNT_W),
        .SATURATE (1'b0)
    ) u_frame_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_handoff),
        .o_count (frame_cnt)
    );

    tnn_sat_counter #(
        .WIDTH    (8),
        .SATURATE (1'b1)
    ) u_drop_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_drop_inc),
        .o_count (drop_cnt)
    );

    assign s_ready  = r_sready;
    assign m_valid  = r_mvalid;
    assign m_frame  = r_out;
    assign err_sync = r_err;

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Scoreboard bench for tnn_feature_framer: stimulus pushes expected frames, a monitor pops them
// at each presented frame. frame_cnt is narrowed to 8 bits so its wrap is reachable quickly.
module tb_tnn_feature_framer;

    localparam int FEAT_W = 3;
    localparam int N_FEAT = 5;
    localparam int CNT_W  = 8;
    localparam int FW     = N_FEAT * FEAT_W;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [FW-1:0]     m_frame;
    logic              err_sync;
    logic [CNT_W-1:0]  frame_cnt;
    logic [7:0]        drop_cnt;

    logic [FW-1:0] expQ[$];
    int testCount;
    int failCount;
    int stallCount;
    int expFrames;
    int expDrops;

    tnn_feature_framer #(
        .FEAT_W (FEAT_W),
        .N_FEAT (N_FEAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_frame   (m_frame),
        .err_sync  (err_sync),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] packFrame(input int a, input int b, input int c,
                                                input int d, input int e);
        logic [2:0] la, lb, lc, ld, le;
        la = a[2:0]; lb = b[2:0]; lc = c[2:0]; ld = d[2:0]; le = e[2:0];
        return {le, ld, lc, lb, la};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] d, input logic last);
        int waits;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waits   = 0;
        while (!s_ready && waits < 50) begin
            @(negedge clk);
            waits++;
            stallCount++;
        end
        if (!s_ready) checkOutput("s_ready_timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic sendFrame(input int a, input int b, input int c, input int d, input int e,
                             input logic lastOnEnd);
        expQ.push_back(packFrame(a, b, c, d, e));
        expFrames = (expFrames + 1) % (1 << CNT_W);
        applyStimulus(3'(a), 1'b0);
        applyStimulus(3'(b), 1'b0);
        applyStimulus(3'(c), 1'b0);
        applyStimulus(3'(d), 1'b0);
        applyStimulus(3'(e), lastOnEnd);
    endtask

    task automatic waitDrain();
        int waits;
        waits = 0;
        while ((expQ.size() != 0 || m_valid) && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("drain_queue", expQ.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: every cycle a frame is presented it must match the queue head; pop on hand-off.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && m_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_frame", int'(m_frame), -1);
                end else begin
                    checkOutput("m_frame", int'(m_frame), int'(expQ[0]));
                    if (m_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount  = 0;
        failCount  = 0;
        stallCount = 0;
        expFrames  = 0;
        expDrops   = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_s_ready", int'(s_ready), 0);
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_m_frame", int'(m_frame), 0);
        checkOutput("rst_err_sync", int'(err_sync), 0);
        checkOutput("rst_frame_cnt", int'(frame_cnt), 0);
        checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("s_ready_after_rst", int'(s_ready), 1);

        // Plain frame with one-cycle latency
        sendFrame(1, 2, 3, 4, 5, 1'b1);
        checkOutput("t1_latency_m_valid", int'(m_valid), 1);
        waitDrain();
        checkOutput("t1_frame_cnt", int'(frame_cnt), expFrames);

        // Back-to-back frames against a stalled consumer
        m_ready = 1'b0;
        sendFrame(2, 4, 6, 1, 3, 1'b1);
        sendFrame(7, 6, 5, 4, 3, 1'b1);
        checkOutput("t2_s_ready_hold", int'(s_ready), 0);
        repeat (3) @(negedge clk);
        checkOutput("t2_m_valid_held", int'(m_valid), 1);
        checkOutput("t2_s_ready_still_low", int'(s_ready), 0);
        m_ready = 1'b1;
        waitDrain();
        checkOutput("t2_frame_cnt", int'(frame_cnt), expFrames);
        checkOutput("t2_s_ready_back", int'(s_ready), 1);

        // Short frame
        applyStimulus(3'd7, 1'b0);
        applyStimulus(3'd7, 1'b0);
        applyStimulus(3'd7, 1'b1);
        expDrops++;
        checkOutput("t3_err_sync", int'(err_sync), 1);
        checkOutput("t3_drop_cnt", int'(drop_cnt), expDrops);
        checkOutput("t3_no_m_valid", int'(m_valid), 0);
        @(negedge clk);
        checkOutput("t3_err_pulse_end", int'(err_sync), 0);
        sendFrame(1, 3, 5, 7, 0, 1'b1);
        waitDrain();

        // Missing s_last: frame still emitted, then resync
        sendFrame(3, 1, 4, 1, 5, 1'b0);
        expDrops++;
        checkOutput("t4_err_sync", int'(err_sync), 1);
        checkOutput("t4_drop_cnt", int'(drop_cnt), expDrops);
        applyStimulus(3'd2, 1'b0);
        applyStimulus(3'd6, 1'b1);
        sendFrame(2, 7, 1, 0, 6, 1'b1);
        waitDrain();
        checkOutput("t4_frame_cnt", int'(frame_cnt), expFrames);
        checkOutput("t4_drop_cnt_final", int'(drop_cnt), expDrops);

        // Reset mid-frame
        applyStimulus(3'd5, 1'b0);
        applyStimulus(3'd5, 1'b0);
        applyStimulus(3'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        expFrames = 0;
        expDrops  = 0;
        checkOutput("t5_s_ready", int'(s_ready), 0);
        checkOutput("t5_m_valid", int'(m_valid), 0);
        checkOutput("t5_m_frame", int'(m_frame), 0);
        checkOutput("t5_err_sync", int'(err_sync), 0);
        checkOutput("t5_frame_cnt", int'(frame_cnt), 0);
        checkOutput("t5_drop_cnt", int'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame(6, 5, 4, 3, 2, 1'b1);
        waitDrain();
        checkOutput("t5_frame_cnt_after", int'(frame_cnt), expFrames);
        checkOutput("t5_err_after", int'(err_sync), 0);

        // Drop counter saturation with err_sync on every short frame
        for (int i = 0; i < 300; i++) begin
            applyStimulus(3'(i), 1'b1);
            if (expDrops < 255) expDrops++;
            checkOutput("t6_err_sync", int'(err_sync), 1);
            checkOutput("t6_drop_cnt", int'(drop_cnt), expDrops);
        end
        checkOutput("t6_drop_sat", int'(drop_cnt), 255);

        // Sustained stream: frame_cnt wraps, no stalls while m_ready stays high
        stallCount = 0;
        for (int f = 0; f < 256; f++) begin
            sendFrame(f % 8, (f + 1) % 8, (f + 3) % 8, (f * 3) % 8, (f + 6) % 8, 1'b1);
        end
        checkOutput("t6_no_stalls", stallCount, 0);
        waitDrain();
        checkOutput("t6_frame_cnt_wrap", int'(frame_cnt), expFrames);
        checkOutput("t6_frame_cnt_is_one", int'(frame_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
